// File: rtl/cfg_sched.sv
// Layer-descriptor scheduler: loads a descriptor table over AXI-Stream, then replays it num_iter
// times onto the CFG port, one descriptor outstanding at a time. Optional counters: CFG_SCHED_PERF_EN.
module cfg_sched #(
  parameter int CFG_BW     = 96,
  parameter int MAX_LAYERS = 8,
  parameter int ITER_BW    = 16,
  localparam int LAYER_BW  = $clog2(MAX_LAYERS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                s_axis_desc_tvalid,
  output logic                s_axis_desc_tready,
  input  logic [CFG_BW-1:0]   s_axis_desc_tdata,
  input  logic                s_axis_desc_tlast,
  input  logic                start,
  input  logic                abort,
  input  logic [ITER_BW-1:0]  num_iter,
  output logic                m_axis_cfg_tvalid,
  input  logic                m_axis_cfg_tready,
  output logic [CFG_BW-1:0]   m_axis_cfg_tdata,
  output logic                m_axis_cfg_tlast,
  input  logic                stage_done,
  output logic                busy,
  output logic                done,
  output logic [LAYER_BW:0]   num_layers,
  output logic [LAYER_BW-1:0] cur_layer,
  output logic [ITER_BW-1:0]  cur_iter,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_stalls,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [LAYER_BW:0]   NL_ONE   = 1;
  localparam logic [LAYER_BW-1:0] PTR_ONE  = 1;
  localparam logic [LAYER_BW-1:0] PTR_LAST = LAYER_BW'(MAX_LAYERS - 1);
  localparam logic [ITER_BW-1:0]  ITER_ONE = 1;

  logic [1:0]          state_q, state_d;
  logic [LAYER_BW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LAYER_BW:0]   num_layers_q, num_layers_d;
  logic [LAYER_BW-1:0] cur_layer_q, cur_layer_d;
  logic [ITER_BW-1:0]  cur_iter_q, cur_iter_d;
  logic [ITER_BW-1:0]  iter_lim_q, iter_lim_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [CFG_BW-1:0]   tdata_q, tdata_d;
  logic                done_q, done_d;

  logic [CFG_BW-1:0]   table_mem [MAX_LAYERS];

  logic                load_fire;
  logic                run_start;
  logic                last_layer;
  logic                last_iter;
  logic [LAYER_BW-1:0] next_layer;
  logic [ITER_BW-1:0]  next_iter;

  // Both streams use AXI semantics: a beat transfers on the edge where valid && ready; the
  // sender holds valid and data stable until then, and ready never waits on valid.
  assign s_axis_desc_tready = rstn && (state_q == ST_IDLE) && !start;
  assign load_fire  = s_axis_desc_tvalid && s_axis_desc_tready;
  assign run_start  = (state_q == ST_IDLE) && start && !abort;
  assign last_layer = ({1'b0, cur_layer_q} == (num_layers_q - NL_ONE));
  assign last_iter  = (cur_iter_q == (iter_lim_q - ITER_ONE));

  always_ff @(posedge clk) begin
    if (load_fire) table_mem[wr_ptr_q] <= s_axis_desc_tdata;
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    num_layers_d = num_layers_q;
    cur_layer_d  = cur_layer_q;
    cur_iter_d   = cur_iter_q;
    iter_lim_d   = iter_lim_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    done_d       = 1'b0;
    next_layer   = last_layer ? '0 : cur_layer_q + PTR_ONE;
    next_iter    = last_layer ? cur_iter_q + ITER_ONE : cur_iter_q;

    // A table is open while wr_ptr is nonzero; its first beat invalidates the previous table.
    if (load_fire) begin
      if (wr_ptr_q == '0) num_layers_d = '0;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (s_axis_desc_tlast || (wr_ptr_q == PTR_LAST)) begin
        num_layers_d = {1'b0, wr_ptr_q} + NL_ONE;
        wr_ptr_d     = '0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (run_start) begin
          if ((num_layers_q == '0) || (num_iter == '0)) begin
            done_d = 1'b1;
          end else begin
            iter_lim_d  = num_iter;
            cur_layer_d = '0;
            cur_iter_d  = '0;
            tdata_d     = table_mem[0];
            tvalid_d    = 1'b1;
            tlast_d     = (num_layers_q == NL_ONE) && (num_iter == ITER_ONE);
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (m_axis_cfg_tready) begin
          tvalid_d = 1'b0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (stage_done) begin
          if (last_layer && last_iter) begin
            done_d  = 1'b1;
            tlast_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            cur_layer_d = next_layer;
            cur_iter_d  = next_iter;
            tdata_d     = table_mem[next_layer];
            tvalid_d    = 1'b1;
            tlast_d     = ({1'b0, next_layer} == (num_layers_q - NL_ONE)) &&
                          (next_iter == (iter_lim_q - ITER_ONE));
            state_d     = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Cancel wins over any handshake or stage_done seen in the same cycle; table is untouched.
    if (abort) begin
      state_d  = ST_IDLE;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      num_layers_q <= '0;
      cur_layer_q  <= '0;
      cur_iter_q   <= '0;
      iter_lim_q   <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      num_layers_q <= num_layers_d;
      cur_layer_q  <= cur_layer_d;
      cur_iter_q   <= cur_iter_d;
      iter_lim_q   <= iter_lim_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      done_q       <= done_d;
    end
  end

`ifdef CFG_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (run_start) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end else begin
      if ((state_q != ST_IDLE) && !(&perf_cycles_q)) perf_cycles_d = perf_cycles_q + 32'd1;
      if ((state_q == ST_ISSUE) && !m_axis_cfg_tready && !(&perf_stalls_q))
        perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

  assign m_axis_cfg_tvalid = tvalid_q;
  assign m_axis_cfg_tdata  = tdata_q;
  assign m_axis_cfg_tlast  = tlast_q;
  assign busy              = (state_q != ST_IDLE);
  assign done              = done_q;
  assign num_layers        = num_layers_q;
  assign cur_layer         = cur_layer_q;
  assign cur_iter          = cur_iter_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_cfg_sched.sv
// Directed bench for cfg_sched: table-driven load vectors plus hand-written run, stall,
// abort and reset sequences; issued descriptors are checked against an expected queue.
module tb_cfg_sched;
  localparam int CFG_BW     = 96;
  localparam int MAX_LAYERS = 8;
  localparam int ITER_BW    = 16;
  localparam int LAYER_BW   = 3;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                s_tvalid = 1'b0;
  logic                s_tready;
  logic [CFG_BW-1:0]   s_tdata = '0;
  logic                s_tlast = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [ITER_BW-1:0]  num_iter = '0;
  logic                m_tvalid;
  logic                m_tready = 1'b0;
  logic [CFG_BW-1:0]   m_tdata;
  logic                m_tlast;
  logic                stage_done = 1'b0;
  logic                busy;
  logic                done;
  logic [LAYER_BW:0]   num_layers;
  logic [LAYER_BW-1:0] cur_layer;
  logic [ITER_BW-1:0]  cur_iter;
  logic [31:0]         perf_cycles;
  logic [31:0]         perf_stalls;
  logic [1:0]          dbg_state;

  cfg_sched #(.CFG_BW(CFG_BW), .MAX_LAYERS(MAX_LAYERS), .ITER_BW(ITER_BW)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_desc_tvalid(s_tvalid), .s_axis_desc_tready(s_tready),
    .s_axis_desc_tdata(s_tdata), .s_axis_desc_tlast(s_tlast),
    .start(start), .abort(abort), .num_iter(num_iter),
    .m_axis_cfg_tvalid(m_tvalid), .m_axis_cfg_tready(m_tready),
    .m_axis_cfg_tdata(m_tdata), .m_axis_cfg_tlast(m_tlast),
    .stage_done(stage_done), .busy(busy), .done(done),
    .num_layers(num_layers), .cur_layer(cur_layer), .cur_iter(cur_iter),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [CFG_BW-1:0] exp_q[$];

  typedef struct {
    logic       start;
    logic       tvalid;
    logic       tlast;
    int         didx;
    logic       exp_tready;
    logic [3:0] exp_nl;
    logic       exp_done;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CFG_BW-1:0] dsc(input int k);
    logic [31:0] kk;
    kk = k;
    return {32'hC0DE0000 | kk, ~kk, kk * 32'd3};
  endfunction

  function automatic vec_t mk(input logic st, input logic v, input logic l, input int d,
                              input logic rdy, input logic [3:0] nl, input logic dn);
    vec_t r;
    r.start = st; r.tvalid = v; r.tlast = l; r.didx = d;
    r.exp_tready = rdy; r.exp_nl = nl; r.exp_done = dn;
    return r;
  endfunction

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = dsc(base + i);
      s_tlast  = (i == n - 1);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Scoreboard: every accepted CFG beat must match the head of the expected queue.
  always @(posedge clk) begin
    if (rstn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) chk("unexpected_issue", 128'(m_tdata), 128'hx);
      else chk("issue_data", 128'(m_tdata), 128'(exp_q.pop_front()));
    end
  end

  logic [31:0] exp_stalls;

  initial begin
`ifdef CFG_SCHED_PERF_EN
    exp_stalls = 32'd10;
`else
    exp_stalls = 32'd0;
`endif
    // start with an empty table, then 8 beats without tlast, idle, 9th beat, 10th with tlast
    vecs[0] = mk(1'b1, 1'b1, 1'b0, 99, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 7; i++) vecs[1 + i] = mk(1'b0, 1'b1, 1'b0, i, 1'b1, 4'd0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 7, 1'b1, 4'd8, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 8, 1'b1, 4'd0, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 9, 1'b1, 4'd2, 1'b0);

    #1;
    chk("rst_tvalid", 128'(m_tvalid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_num_layers", 128'(num_layers), 128'd0);
    chk("rst_tready", 128'(s_tready), 128'd0);
    chk("rst_perf_cycles", 128'(perf_cycles), 128'd0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // Load table vectors (start in vector 0 exercises the empty-table done path)
    num_iter = 16'd2;
    for (int v = 0; v < 11; v++) begin
      start    = vecs[v].start;
      s_tvalid = vecs[v].tvalid;
      s_tlast  = vecs[v].tlast;
      s_tdata  = dsc(vecs[v].didx);
      #1;
      chk($sformatf("vec%0d_tready", v), 128'(s_tready), 128'(vecs[v].exp_tready));
      tick();
      chk($sformatf("vec%0d_num_layers", v), 128'(num_layers), 128'(vecs[v].exp_nl));
      chk($sformatf("vec%0d_done", v), 128'(done), 128'(vecs[v].exp_done));
      chk($sformatf("vec%0d_tvalid", v), 128'(m_tvalid), 128'd0);
    end
    start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;

    // start with num_iter=0 on a loaded table
    num_iter = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_iter_done", 128'(done), 128'd1);
    chk("zero_iter_busy", 128'(busy), 128'd0);
    chk("zero_iter_tvalid", 128'(m_tvalid), 128'd0);
    tick();
    chk("zero_iter_done_pulse", 128'(done), 128'd0);
    chk("zero_iter_tvalid2", 128'(m_tvalid), 128'd0);

    // Two passes over D0..D2
    load(16, 3);
    chk("t1_num_layers", 128'(num_layers), 128'd3);
    num_iter = 16'd2;
    m_tready = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(dsc(16 + (k % 3)));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t1_tvalid%0d", k), 128'(m_tvalid), 128'd1);
      chk($sformatf("t1_tdata%0d", k), 128'(m_tdata), 128'(dsc(16 + (k % 3))));
      chk($sformatf("t1_tlast%0d", k), 128'(m_tlast), 128'(k == 5));
      chk($sformatf("t1_layer%0d", k), 128'(cur_layer), 128'(k % 3));
      chk($sformatf("t1_iter%0d", k), 128'(cur_iter), 128'(k / 3));
      tick();
      chk($sformatf("t1_tvalid_drop%0d", k), 128'(m_tvalid), 128'd0);
      repeat (4) tick();
      stage_done = 1'b1;
      tick();
      stage_done = 1'b0;
    end
    chk("t1_done", 128'(done), 128'd1);
    chk("t1_tvalid_end", 128'(m_tvalid), 128'd0);
    tick();
    chk("t1_done_pulse", 128'(done), 128'd0);
    chk("t1_busy_end", 128'(busy), 128'd0);
    chk("t1_queue_empty", 128'(exp_q.size()), 128'd0);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    chk("idle_stage_done_ignored", 128'(busy), 128'd0);

    // Backpressure: tready low for 10 cycles in ISSUE
    m_tready = 1'b0;
    num_iter = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t2_hold_valid%0d", i), 128'(m_tvalid), 128'd1);
      chk($sformatf("t2_hold_data%0d", i), 128'(m_tdata), 128'(dsc(16)));
      tick();
    end
    chk("t2_perf_stalls", 128'(perf_stalls), 128'(exp_stalls));
    chk("t2_layer_held", 128'(cur_layer), 128'd0);
    exp_q.push_back(dsc(16));
    m_tready = 1'b1;
    tick();
    chk("t2_after_hs", 128'(m_tvalid), 128'd0);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    chk("t2_next_valid", 128'(m_tvalid), 128'd1);
    chk("t2_next_data", 128'(m_tdata), 128'(dsc(17)));
    exp_q.push_back(dsc(17));
    tick();
    chk("t5_wait_layer", 128'(cur_layer), 128'd1);
    chk("t5_wait_busy", 128'(busy), 128'd1);

    // Abort in WAIT at layer 1, colliding with stage_done
    abort = 1'b1;
    stage_done = 1'b1;
    tick();
    abort = 1'b0;
    stage_done = 1'b0;
    chk("t5_abort_busy", 128'(busy), 128'd0);
    chk("t5_abort_tvalid", 128'(m_tvalid), 128'd0);
    chk("t5_abort_done", 128'(done), 128'd0);
    chk("t5_abort_num_layers", 128'(num_layers), 128'd3);
    tick();
    chk("t5_abort_no_done", 128'(done), 128'd0);
    m_tready = 1'b0;
    num_iter = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_restart_valid", 128'(m_tvalid), 128'd1);
    chk("t5_restart_data", 128'(m_tdata), 128'(dsc(16)));
    chk("t5_restart_layer", 128'(cur_layer), 128'd0);
    chk("t5_restart_iter", 128'(cur_iter), 128'd0);

    // Asynchronous reset mid-ISSUE
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_tvalid", 128'(m_tvalid), 128'd0);
    chk("t6_busy", 128'(busy), 128'd0);
    chk("t6_num_layers", 128'(num_layers), 128'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("t6_tready", 128'(s_tready), 128'd1);
    chk("t6_num_layers_after", 128'(num_layers), 128'd0);
    chk("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
